// File: rtl/mem_responder.sv
// mem_responder: word RAM with byte-lane writes plus an IO page holding an
// LED register and an 8N1 UART transmitter, serving the core's strobe bus.
//
// Strobe protocol: there is no ready/valid back-pressure. A nonzero
// mem_wstrb commits a write on that clock edge. mem_rstrb=1 samples a read
// on that edge, and mem_rdata holds the result from just after that edge
// until the next sampled read.
module mem_responder #(
    parameter int MEM_WORDS   = 1024,
    parameter     INIT_FILE   = "",
    parameter int CLK_PER_BIT = 868,
    parameter int LED_W       = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [31:0]      mem_addr,
    input  logic [31:0]      mem_wdata,
    input  logic [3:0]       mem_wstrb,
    input  logic             mem_rstrb,
    output logic [31:0]      mem_rdata,
    output logic [LED_W-1:0] leds,
    output logic             uart_tx
);

    localparam int AW = $clog2(MEM_WORDS);
    localparam int BW = (CLK_PER_BIT > 1) ? $clog2(CLK_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLK_PER_BIT - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    logic [31:0]     ram [MEM_WORDS];
    logic            ram_sel;
    logic [AW-1:0]   ram_idx;
    logic [1:0]      io_reg;
    logic            wr_en;
    logic            uart_wr;
    logic            uart_accept;
    logic            busy;
    logic            baud_last;
    logic [31:0]     led_ext;
    logic [31:0]     io_rdata;
    logic            unused_addr_bits;

    uart_state_e     state_q, state_d;
    logic [BW-1:0]   baud_q, baud_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      data_q, data_d;
    logic            tx_q, tx_d;
    logic            overflow_q, overflow_d;
    logic [LED_W-1:0] leds_q, leds_d;
    logic [31:0]     rdata_q, rdata_d;

    // Address bits above the RAM index (other than the IO select) only alias.
    assign unused_addr_bits = ^mem_addr;

    assign ram_sel     = ~mem_addr[22];
    assign ram_idx     = mem_addr[AW+1:2];
    assign io_reg      = mem_addr[3:2];
    assign wr_en       = |mem_wstrb;
    assign busy        = (state_q != ST_IDLE);
    assign uart_wr     = ~ram_sel && (io_reg == 2'd1) && mem_wstrb[0];
    assign uart_accept = uart_wr && !busy;
    assign baud_last   = (baud_q == BAUD_LAST);

    // RAM byte-lane writes; contents are deliberately not reset.
    always_ff @(posedge clk) begin
        if (ram_sel && wr_en) begin
            for (int i = 0; i < 4; i++) begin
                if (mem_wstrb[i]) ram[ram_idx][8*i +: 8] <= mem_wdata[8*i +: 8];
            end
        end
    end

    // UART next-state: baud counter paces each of the ten bit periods.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q;
        bit_d   = bit_q;
        data_d  = data_q;
        tx_d    = 1'b1;
        case (state_q)
            ST_IDLE: begin
                if (uart_accept) begin
                    state_d = ST_START;
                    baud_d  = '0;
                    bit_d   = 3'd0;
                    data_d  = mem_wdata[7:0];
                end
            end
            ST_START: begin
                if (baud_last) begin
                    state_d = ST_DATA;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (baud_last) begin
                    baud_d = '0;
                    if (bit_q == 3'd7) state_d = ST_STOP;
                    else               bit_d   = bit_q + 3'd1;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (baud_last) begin
                    state_d = ST_IDLE;
                    baud_d  = '0;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        // Line level is registered from the next state so uart_tx never glitches.
        case (state_d)
            ST_START: tx_d = 1'b0;
            ST_DATA:  tx_d = data_d[bit_d];
            default:  tx_d = 1'b1;
        endcase
    end

    // IO register updates and read-data selection.
    always_comb begin
        overflow_d = overflow_q;
        leds_d     = leds_q;
        rdata_d    = rdata_q;
        led_ext    = '0;
        led_ext[LED_W-1:0] = leds_q;
        if (uart_wr && busy) overflow_d = 1'b1;
        if (~ram_sel && (io_reg == 2'd2) && wr_en) overflow_d = 1'b0;
        if (~ram_sel && (io_reg == 2'd0)) begin
            for (int b = 0; b < LED_W; b++) begin
                if (mem_wstrb[b/8]) leds_d[b] = mem_wdata[b];
            end
        end
        case (io_reg)
            2'd0:    io_rdata = led_ext;
            2'd2:    io_rdata = {30'b0, overflow_q, busy};
            default: io_rdata = 32'h0;
        endcase
        if (mem_rstrb) rdata_d = ram_sel ? ram[ram_idx] : io_rdata;
    end

    // State register; reset forces the line idle-high at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            baud_q     <= '0;
            bit_q      <= 3'd0;
            data_q     <= 8'h00;
            tx_q       <= 1'b1;
            overflow_q <= 1'b0;
            leds_q     <= '0;
            rdata_q    <= 32'h0;
        end else begin
            state_q    <= state_d;
            baud_q     <= baud_d;
            bit_q      <= bit_d;
            data_q     <= data_d;
            tx_q       <= tx_d;
            overflow_q <= overflow_d;
            leds_q     <= leds_d;
            rdata_q    <= rdata_d;
        end
    end

    assign mem_rdata = rdata_q;
    assign leds      = leds_q;
    assign uart_tx   = tx_q;

endmodule
